// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg
// Shared types and constants for the ID-stage hazard/forwarding unit.
//   fwd_sel_e   : operand-forwarding select encoding. The same encoding
//                 drives MUX_ID_FW_P.
//   sb_entry_t  : one destination-scoreboard slot {rd, we, ld}.
//   BUBBLE      : an empty slot. It is inserted whenever the control unit
//                 zeroes the instruction in ID.
//   slot_hits() : producer-match test. GR0 never matches.
package hazard_fwd_unit_pkg;

  localparam int SB_RW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic [SB_RW-1:0] rd;
    logic             we;
    logic             ld;
  } sb_entry_t;

  localparam sb_entry_t BUBBLE = '{rd: '0, we: 1'b0, ld: 1'b0};

  // A slot produces register r only if it writes the file, targets r and
  // r is not the hard-wired zero register.
  function automatic logic slot_hits(input sb_entry_t e, input logic [SB_RW-1:0] r);
    return e.we && (e.rd == r) && (r != {SB_RW{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
// Bundle between the ID stage / pipeline control and the hazard unit.
//   ID_RA/ID_RB/ID_RD, ID_USES_A/B, ID_RF_LE, ID_L : decoded ID instruction
//   EX_J                                           : taken jump resolved in EX
//   A_S/B_S                                        : forwarding selects
//   IF_S, PC_LE, IFID_LE, IFID_FLUSH, CU_S         : pipeline control
//   STALL_CNT/FLUSH_CNT                            : saturating event counters
// The master modport is the pipeline side. The slave modport is the hazard unit.
interface hazard_fwd_unit_if #(
  parameter int RW    = 5,
  parameter int CNT_W = 16
);
  logic [RW-1:0]    ID_RA;
  logic [RW-1:0]    ID_RB;
  logic             ID_USES_A;
  logic             ID_USES_B;
  logic [RW-1:0]    ID_RD;
  logic             ID_RF_LE;
  logic             ID_L;
  logic             EX_J;
  logic [1:0]       A_S;
  logic [1:0]       B_S;
  logic             IF_S;
  logic             PC_LE;
  logic             IFID_LE;
  logic             IFID_FLUSH;
  logic             CU_S;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output ID_RA, ID_RB, ID_USES_A, ID_USES_B, ID_RD, ID_RF_LE, ID_L, EX_J,
    input  A_S, B_S, IF_S, PC_LE, IFID_LE, IFID_FLUSH, CU_S, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RA, ID_RB, ID_USES_A, ID_USES_B, ID_RD, ID_RF_LE, ID_L, EX_J,
    output A_S, B_S, IF_S, PC_LE, IFID_LE, IFID_FLUSH, CU_S, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// hazard_fwd_unit_fwd_select
// Forwarding select for one ID source operand.
//   src_i    : source register specifier
//   use_i    : the instruction actually reads this operand
//   ex_i/mem_i/wb_i : scoreboard slots, youngest first
//   sel_o    : FWD_RF / FWD_EX / FWD_MEM / FWD_WB
//   ex_hit_o : the EX slot produces this (used) operand; feeds load-use detection
module hazard_fwd_unit_fwd_select
  import hazard_fwd_unit_pkg::*;
#(
  parameter int RW = SB_RW
) (
  input  logic [RW-1:0] src_i,
  input  logic          use_i,
  input  sb_entry_t     ex_i,
  input  sb_entry_t     mem_i,
  input  sb_entry_t     wb_i,
  output fwd_sel_e      sel_o,
  output logic          ex_hit_o
);

  // Priority pick: the youngest in-flight producer wins.
  always_comb begin
    sel_o    = FWD_RF;
    ex_hit_o = 1'b0;
    if (!use_i) begin
      sel_o = FWD_RF;
    end else if (slot_hits(ex_i, src_i)) begin
      sel_o    = FWD_EX;
      ex_hit_o = 1'b1;
    end else if (slot_hits(mem_i, src_i)) begin
      sel_o = FWD_MEM;
    end else if (slot_hits(wb_i, src_i)) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// ID-stage hazard and forwarding control for the 5-stage PA-RISC core.
//   CLK : rising-edge clock
//   RST : synchronous active-low reset
//   bus : hazard_fwd_unit_if.slave. It carries the decoded ID instruction
//         and EX_J in, and the forwarding selects, pipeline control and
//         event counters out.
// The unit keeps a private 3-slot destination scoreboard (EX, MEM, WB) that
// shifts every clock. Therefore no forwarding decision depends on
// downstream stage wiring. All outputs are combinational from the
// scoreboard and the current inputs.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int RW    = SB_RW,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  hazard_fwd_unit_if.slave   bus
);

  sb_entry_t slot_ex_q,  slot_ex_d;
  sb_entry_t slot_mem_q, slot_mem_d;
  sb_entry_t slot_wb_q,  slot_wb_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  fwd_sel_e a_sel_s;
  fwd_sel_e b_sel_s;
  logic     a_ex_hit_s;
  logic     b_ex_hit_s;
  logic     load_use_s;
  logic     stall_s;

  logic     if_s_s;
  logic     pc_le_s;
  logic     ifid_le_s;
  logic     ifid_flush_s;
  logic     cu_s_s;

  sb_entry_t id_entry_s;

  hazard_fwd_unit_fwd_select #(.RW(RW)) u_fwd_select_a (
    .src_i    (bus.ID_RA),
    .use_i    (bus.ID_USES_A),
    .ex_i     (slot_ex_q),
    .mem_i    (slot_mem_q),
    .wb_i     (slot_wb_q),
    .sel_o    (a_sel_s),
    .ex_hit_o (a_ex_hit_s)
  );

  hazard_fwd_unit_fwd_select #(.RW(RW)) u_fwd_select_b (
    .src_i    (bus.ID_RB),
    .use_i    (bus.ID_USES_B),
    .ex_i     (slot_ex_q),
    .mem_i    (slot_mem_q),
    .wb_i     (slot_wb_q),
    .sel_o    (b_sel_s),
    .ex_hit_o (b_ex_hit_s)
  );

  // A load's data is not ready until the end of MEM. A dependent instruction
  // right behind it must therefore wait one cycle. A taken jump squashes that
  // instruction anyway, so the flush cancels the stall.
  assign load_use_s = slot_ex_q.ld && (a_ex_hit_s || b_ex_hit_s);
  assign stall_s    = load_use_s && !bus.EX_J;

  // Pipeline control: jump flush has priority over the load-use stall.
  always_comb begin
    if_s_s       = 1'b0;
    pc_le_s      = 1'b1;
    ifid_le_s    = 1'b1;
    ifid_flush_s = 1'b0;
    cu_s_s       = 1'b0;
    if (bus.EX_J) begin
      if_s_s       = 1'b1;
      pc_le_s      = 1'b1;
      ifid_le_s    = 1'b1;
      ifid_flush_s = 1'b1;
      cu_s_s       = 1'b1;
    end else if (stall_s) begin
      pc_le_s   = 1'b0;
      ifid_le_s = 1'b0;
      cu_s_s    = 1'b1;
    end else begin
      if_s_s       = 1'b0;
      ifid_flush_s = 1'b0;
    end
  end

  // The entry entering EX mirrors what MUX_CU lets through. A zeroed
  // instruction becomes a bubble, so it never forwards or stalls.
  always_comb begin
    id_entry_s = BUBBLE;
    if (cu_s_s) begin
      id_entry_s = BUBBLE;
    end else begin
      id_entry_s = '{rd: bus.ID_RD, we: bus.ID_RF_LE, ld: bus.ID_L};
    end
  end

  // Scoreboard shift and saturating counter next-state.
  always_comb begin
    slot_ex_d   = id_entry_s;
    slot_mem_d  = slot_ex_q;
    slot_wb_d   = slot_mem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (bus.EX_J && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers; reset empties the scoreboard and clears the counters.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      slot_ex_q   <= BUBBLE;
      slot_mem_q  <= BUBBLE;
      slot_wb_q   <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slot_ex_q   <= slot_ex_d;
      slot_mem_q  <= slot_mem_d;
      slot_wb_q   <= slot_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.A_S        = a_sel_s;
  assign bus.B_S        = b_sel_s;
  assign bus.IF_S       = if_s_s;
  assign bus.PC_LE      = pc_le_s;
  assign bus.IFID_LE    = ifid_le_s;
  assign bus.IFID_FLUSH = ifid_flush_s;
  assign bus.CU_S       = cu_s_s;
  assign bus.STALL_CNT  = stall_cnt_q;
  assign bus.FLUSH_CNT  = flush_cnt_q;

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline control block for the 5-stage PA-RISC core. Sits beside the ID stage and tracks the destination registers of instructions in flight through EX, MEM and WB.
- Produces the ID operand-forwarding selects, load-use stalls (PC/IF-ID hold plus a control-unit NOP bubble), and the squash of the two younger instructions on a taken EX jump.
- Keeps its own 3-slot destination scoreboard, advanced every clock, so forwarding decisions do not depend on downstream stage wiring.

Parameters:
- RW, 5, register-specifier width.
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-low.
- ID_RA  in  RW  source register A of the instruction in ID.
- ID_RB  in  RW  source register B after the SHF mux.
- ID_USES_A  in  1  instruction in ID reads RA.
- ID_USES_B  in  1  instruction in ID reads RB.
- ID_RD  in  RW  destination (IDR) of the instruction in ID.
- ID_RF_LE  in  1  instruction in ID writes the register file.
- ID_L  in  1  instruction in ID is a load.
- EX_J  in  1  taken jump/branch resolved in EX.
- A_S  out  2  forwarding select for FPA: 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
- B_S  out  2  forwarding select for FPB, same encoding.
- IF_S  out  1  PC mux select (1 = take TA).
- PC_LE  out  1  PC front/back register load enable.
- IFID_LE  out  1  IF/ID pipeline register load enable.
- IFID_FLUSH  out  1  loads a NOP into IF/ID.
- CU_S  out  1  MUX_CU select (1 = zero all control signals, i.e. a bubble).
- STALL_CNT  out  CNT_W  count of load-use stall cycles.
- FLUSH_CNT  out  CNT_W  count of taken-jump flushes.

Behaviour:
- Scoreboard: three slots (EX, MEM, WB), each holding {rd, we, ld}. Each clock: WB <= MEM, MEM <= EX, EX <= the incoming ID entry.
  - The incoming entry is {ID_RD, ID_RF_LE, ID_L}, except it is a bubble {0, 0, 0} when CU_S = 1.
  - A slot "hits" register r only if we = 1, rd == r and r != 0. GR0 is never forwarded.
- Forwarding (combinational from slots and ID inputs):
  - A_S = 01 on an EX hit on ID_RA, else 10 on a MEM hit, else 11 on a WB hit, else 00. Youngest producer wins.
  - A_S is 00 whenever ID_USES_A = 0. B_S follows the same rules using ID_RB and ID_USES_B.
- Load-use stall:
  - Condition: the EX slot has ld = 1 and hits a used source.
  - Action: PC_LE = 0, IFID_LE = 0, CU_S = 1 for exactly one cycle. The load moves to MEM and the next cycle forwards with select 10.
  - During the stall cycle A_S/B_S still report the EX hit; the value is don't-care because the instruction becomes a bubble.
- Taken jump (EX_J = 1):
  - IF_S = 1, PC_LE = 1, IFID_LE = 1, IFID_FLUSH = 1, CU_S = 1.
  - The instruction in ID and the one being fetched are squashed. There is no delay slot.
  - A flush overrides a simultaneous load-use stall: PC_LE = 1 and the stall is not counted.
- Idle (no stall, no jump): PC_LE = 1, IFID_LE = 1, IF_S = 0, IFID_FLUSH = 0, CU_S = 0.
- Counters:
  - STALL_CNT increments on each stall cycle; FLUSH_CNT increments on each EX_J cycle.
  - Both saturate at all-ones and do not wrap.
- Reset (RST = 0 at a clock edge):
  - All slots are cleared to {0, 0, 0} and both counters to 0.
  - Outputs therefore become A_S = B_S = 00 and PC_LE = IFID_LE = 1, with IF_S, IFID_FLUSH and CU_S = 0 unless EX_J = 1 or a stall condition holds that cycle.
  - A reset during a stall or flush takes priority; the first cycle after reset sees an empty scoreboard.
- Latency: all outputs are combinational from state and current inputs. State updates on the following edge.

Decomposition:
- Shared package:
  - FWD_RF, FWD_EX, FWD_MEM, FWD_WB select encodings (shared with MUX_ID_FW_P).
  - Scoreboard entry typedef {rd, we, ld}.
  - BUBBLE entry constant.
- One natural sub-module, fwd_select, is instantiated twice (for A and B). Inputs: source register, use flag, three slots. Output: 2-bit select.

Test Plan:
- Reset with RST = 0 for 2 cycles, then release with ID_USES_A/B = 0 -> A_S = B_S = 00, PC_LE = 1, STALL_CNT = FLUSH_CNT = 0.
- ADD r3 (ID_RD = 3, ID_RF_LE = 1), then next cycle ID_RA = 3, ID_USES_A = 1 -> A_S = 01. Hold ID_RA = 3 with non-writing instructions: next cycles show 10, then 11, then 00.
- LDW r5 (ID_L = 1), then next cycle ID_RB = 5, ID_USES_B = 1 -> stall cycle with PC_LE = 0, IFID_LE = 0, CU_S = 1, STALL_CNT = 1. The following cycle gives B_S = 10 and PC_LE = 1.
- Writer to r0, then a reader of r0 -> A_S = 00 and no stall, even if the writer is a load.
- EX_J = 1 coinciding with a load-use condition -> IF_S = 1, IFID_FLUSH = 1, CU_S = 1, PC_LE = 1, FLUSH_CNT = 1, STALL_CNT unchanged. The next cycle's EX slot is a bubble, so no forwarding hit.
- Force 65535 stalls, then one more -> STALL_CNT stays 0xFFFF. Assert RST = 0 mid-stall -> next cycle STALL_CNT = 0 and PC_LE = 1.
